// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 memory access stage.
//   XLEN / CU_W      : data and control-bundle widths
//   CU_MEM_WRITE/READ: bit positions of the store/load strobes in the control bundle
//   F3_*             : funct3 access size/sign encodings
//   mem_state_t      : stage FSM states
//   is_misaligned()  : alignment check used when the misalignment trap is built in
package riscv_pkg;

    localparam int XLEN         = 32;
    localparam int CU_W         = 8;
    localparam int CU_MEM_WRITE = 4;
    localparam int CU_MEM_READ  = 3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUS  = 1'b1
    } mem_state_t;

    // Halves need a[0]=0, words (and every undefined code, which acts as a word) need a[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a_lo);
        logic mis;
        case (f3)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = a_lo[0];
            default:     mis = (a_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data bus between the memory access stage (master) and memory (slave).
//   dbus_req   : access request, held until dbus_ack
//   dbus_we    : 1 = store
//   dbus_addr  : word-aligned address
//   dbus_be    : byte enables
//   dbus_wdata : lane-replicated store data
//   dbus_ack   : access complete; dbus_rdata valid for loads
//   dbus_rdata : load word
interface memory_access_stage_if;
    import riscv_pkg::*;

    logic            dbus_req;
    logic            dbus_we;
    logic [XLEN-1:0] dbus_addr;
    logic [3:0]      dbus_be;
    logic [XLEN-1:0] dbus_wdata;
    logic            dbus_ack;
    logic [XLEN-1:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_ack, dbus_rdata
    );

endinterface

// File: rtl/load_store_align.sv
// Combinational lane steering for the memory access stage.
//   addr_lo    in  : address bits [1:0]
//   funct3     in  : access size/sign
//   store_data in  : unshifted store data (rs2)
//   rdata      in  : raw load word from the bus
//   be         out : byte enables
//   wdata      out : store data replicated across the lanes
//   load_data  out : selected lane, sign- or zero-extended
module load_store_align
    import riscv_pkg::*;
(
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword out of the load word.
    always_comb begin
        byte_s = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Byte enables and store replication; undefined sizes behave as words.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3)
            F3_B, F3_BU: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            F3_H, F3_HU: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Load extension; undefined sizes return the whole word.
    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   load_data = {24'd0, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_HU:   load_data = {16'd0, half_s};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// RV32 MEM stage between EX/MEM and MEM/WB. Non-memory ops pass through in one
// cycle; loads/stores run on a req/ack data bus while upstream is stalled.
// Optional build macro: MEM_MISALIGN_TRAP_EN -- misaligned halves/words skip the
// bus, complete in one cycle and raise o_misalign (faulting address in o_result).
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   in_valid, rd, alu_out,
//   mem_write_data,
//   control_unit_signal,
//   funct3                  : EX/MEM inputs
//   dbus                    : data bus master (memory_access_stage_if)
//   stall                   : upstream must hold its outputs
//   o_valid, o_rd,
//   o_control_unit_signal,
//   o_result, o_misalign    : MEM/WB outputs
module memory_access_stage
    import riscv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [4:0]             rd,
    input  logic [XLEN-1:0]        alu_out,
    input  logic [XLEN-1:0]        mem_write_data,
    input  logic [CU_W-1:0]        control_unit_signal,
    input  logic [2:0]             funct3,
    memory_access_stage_if.master  dbus,
    output logic                   stall,
    output logic                   o_valid,
    output logic [4:0]             o_rd,
    output logic [CU_W-1:0]        o_control_unit_signal,
    output logic [XLEN-1:0]        o_result,
    output logic                   o_misalign
);

    mem_state_t      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] sdata_q, sdata_d;
    logic [2:0]      f3_q, f3_d;
    logic            we_q, we_d;
    logic [4:0]      o_rd_q, o_rd_d;
    logic [CU_W-1:0] o_cu_q, o_cu_d;
    logic            o_valid_q, o_valid_d;
    logic [XLEN-1:0] o_result_q, o_result_d;
    logic            o_mis_q, o_mis_d;

    logic            memop_s;
    logic            mis_s;
    logic            bus_active_s;
    logic [3:0]      be_s;
    logic [XLEN-1:0] wdata_s;
    logic [XLEN-1:0] load_s;

    assign memop_s = in_valid & (control_unit_signal[CU_MEM_WRITE] | control_unit_signal[CU_MEM_READ]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_s = is_misaligned(funct3, alu_out[1:0]);
`else
    assign mis_s = 1'b0;
`endif

    // Lanes are derived from the latched access so bus outputs stay stable until ack.
    load_store_align u_align (
        .addr_lo    (addr_q[1:0]),
        .funct3     (f3_q),
        .store_data (sdata_q),
        .rdata      (dbus.dbus_rdata),
        .be         (be_s),
        .wdata      (wdata_s),
        .load_data  (load_s)
    );

    // Next-state and next-output logic of the IDLE/BUS FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        f3_d       = f3_q;
        we_d       = we_q;
        o_rd_d     = o_rd_q;
        o_cu_d     = o_cu_q;
        o_result_d = o_result_q;
        o_valid_d  = 1'b0;
        o_mis_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop_s && !mis_s) begin
                    state_d = BUS;
                    addr_d  = alu_out;
                    sdata_d = mem_write_data;
                    f3_d    = funct3;
                    we_d    = control_unit_signal[CU_MEM_WRITE];
                    o_rd_d  = rd;
                    o_cu_d  = control_unit_signal;
                end else if (in_valid) begin
                    // Non-memops and trapped misaligned accesses retire in one cycle.
                    o_valid_d  = 1'b1;
                    o_rd_d     = rd;
                    o_cu_d     = control_unit_signal;
                    o_result_d = alu_out;
                    o_mis_d    = memop_s & mis_s;
                end else begin
                    o_valid_d = 1'b0;
                end
            end
            BUS: begin
                if (dbus.dbus_ack) begin
                    state_d    = IDLE;
                    o_valid_d  = 1'b1;
                    o_result_d = we_q ? addr_q : load_s;
                end else begin
                    state_d = BUS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= 32'd0;
            sdata_q    <= 32'd0;
            f3_q       <= 3'd0;
            we_q       <= 1'b0;
            o_rd_q     <= 5'd0;
            o_cu_q     <= 8'd0;
            o_valid_q  <= 1'b0;
            o_result_q <= 32'd0;
            o_mis_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            f3_q       <= f3_d;
            we_q       <= we_d;
            o_rd_q     <= o_rd_d;
            o_cu_q     <= o_cu_d;
            o_valid_q  <= o_valid_d;
            o_result_q <= o_result_d;
            o_mis_q    <= o_mis_d;
        end
    end

    // Reset gating drops the request in the same cycle rst is seen.
    assign bus_active_s    = ~rst & (state_q == BUS);
    assign dbus.dbus_req   = bus_active_s;
    assign dbus.dbus_we    = bus_active_s & we_q;
    assign dbus.dbus_addr  = bus_active_s ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dbus.dbus_be    = bus_active_s ? be_s : 4'b0000;
    assign dbus.dbus_wdata = bus_active_s ? wdata_s : 32'd0;

    assign stall = ~rst & (((state_q == IDLE) & memop_s & ~mis_s) |
                           ((state_q == BUS) & ~dbus.dbus_ack));

    assign o_valid               = o_valid_q;
    assign o_rd                  = o_rd_q;
    assign o_control_unit_signal = o_cu_q;
    assign o_result              = o_result_q;
    assign o_misalign            = o_mis_q;

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  rd;
    logic [31:0] alu_out;
    logic [31:0] mem_write_data;
    logic [7:0]  cu;
    logic [2:0]  funct3;
    logic        stall;
    logic        o_valid;
    logic [4:0]  o_rd;
    logic [7:0]  o_cu;
    logic [31:0] o_result;
    logic        o_misalign;

    memory_access_stage_if dbus ();

    memory_access_stage dut (
        .clk                   (clk),
        .rst                   (rst),
        .in_valid              (in_valid),
        .rd                    (rd),
        .alu_out               (alu_out),
        .mem_write_data        (mem_write_data),
        .control_unit_signal   (cu),
        .funct3                (funct3),
        .dbus                  (dbus.master),
        .stall                 (stall),
        .o_valid               (o_valid),
        .o_rd                  (o_rd),
        .o_control_unit_signal (o_cu),
        .o_result              (o_result),
        .o_misalign            (o_misalign)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  cu;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          waits;
        logic [4:0]  rd;
        logic        bus;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] result;
        logic        mis;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    initial begin
        // cu, f3, addr, sdata, rdata, waits, rd, bus, we, be, wdata, result, mis
        vecs[0]  = '{8'h20, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0, 5'd5, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0000_1234, 1'b0};
        vecs[1]  = '{8'h10, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0, 5'd1, 1'b1, 1'b1, 4'b1000, 32'hDDDD_DDDD, 32'h0000_1003, 1'b0};
        vecs[2]  = '{8'h08, 3'b000, 32'h0000_2001, 32'h5566_7788, 32'h0000_8000, 3, 5'd2, 1'b1, 1'b0, 4'b0010, 32'h8888_8888, 32'hFFFF_FF80, 1'b0};
        vecs[3]  = '{8'h08, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 1, 5'd3, 1'b1, 1'b0, 4'b1100, 32'h0, 32'h0000_BEEF, 1'b0};
        vecs[4]  = '{8'h08, 3'b010, 32'h0000_2004, 32'h0, 32'h1234_5678, 0, 5'd4, 1'b1, 1'b0, 4'b1111, 32'h0, 32'h1234_5678, 1'b0};
        vecs[5]  = '{8'h10, 3'b001, 32'h0000_1002, 32'h0000_CAFE, 32'h0, 2, 5'd6, 1'b1, 1'b1, 4'b1100, 32'hCAFE_CAFE, 32'h0000_1002, 1'b0};
        vecs[6]  = '{8'h08, 3'b001, 32'h0000_2000, 32'h0, 32'h0000_F00D, 0, 5'd7, 1'b1, 1'b0, 4'b0011, 32'h0, 32'hFFFF_F00D, 1'b0};
        vecs[7]  = '{8'h08, 3'b100, 32'h0000_2003, 32'h0, 32'h9A00_0000, 1, 5'd8, 1'b1, 1'b0, 4'b1000, 32'h0, 32'h0000_009A, 1'b0};
        vecs[8]  = '{8'h18, 3'b010, 32'h0000_4000, 32'h1122_3344, 32'hFFFF_FFFF, 0, 5'd9, 1'b1, 1'b1, 4'b1111, 32'h1122_3344, 32'h0000_4000, 1'b0};
        vecs[9]  = '{8'h0B, 3'b011, 32'h0000_2008, 32'hA5A5_A5A5, 32'hCAFE_BABE, 0, 5'd10, 1'b1, 1'b0, 4'b1111, 32'hA5A5_A5A5, 32'hCAFE_BABE, 1'b0};
`ifdef MEM_MISALIGN_TRAP_EN
        vecs[10] = '{8'h08, 3'b010, 32'h0000_3002, 32'h0, 32'hDEAD_BEEF, 0, 5'd11, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0000_3002, 1'b1};
`else
        vecs[10] = '{8'h08, 3'b010, 32'h0000_3002, 32'h0, 32'hDEAD_BEEF, 0, 5'd11, 1'b1, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0};
`endif

        rst              = 1'b1;
        in_valid         = 1'b1;
        rd               = 5'd3;
        alu_out          = 32'h0000_2000;
        mem_write_data   = 32'h0;
        cu               = 8'h08;
        funct3           = 3'b010;
        dbus.dbus_ack    = 1'b0;
        dbus.dbus_rdata  = 32'h0;

        // Reset: all outputs zero even with a live memop on the inputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst stall", {31'd0, stall}, 32'd0);
        check("rst req", {31'd0, dbus.dbus_req}, 32'd0);
        check("rst o_valid", {31'd0, o_valid}, 32'd0);
        check("rst o_result", o_result, 32'd0);
        check("rst o_rd", {27'd0, o_rd}, 32'd0);
        check("rst o_cu", {24'd0, o_cu}, 32'd0);
        check("rst o_misalign", {31'd0, o_misalign}, 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;

        for (int i = 0; i < NV; i++) begin
            int stall_cnt;
            vec_t v;
            v         = vecs[i];
            stall_cnt = 0;
            @(negedge clk);
            in_valid       = 1'b1;
            rd             = v.rd;
            alu_out        = v.addr;
            mem_write_data = v.sdata;
            cu             = v.cu;
            funct3         = v.f3;
            #1;
            check($sformatf("v%0d idle stall", i), {31'd0, stall}, {31'd0, v.bus});
            check($sformatf("v%0d idle req", i), {31'd0, dbus.dbus_req}, 32'd0);
            if (stall) stall_cnt++;
            @(posedge clk);
            @(negedge clk);
            // Inputs are ignored while the access is on the bus.
            in_valid       = 1'b0;
            alu_out        = 32'hFFFF_FFFF;
            mem_write_data = 32'h0;
            cu             = 8'h00;
            funct3         = 3'b111;
            rd             = 5'd31;
            if (v.bus) begin
                #1;
                check($sformatf("v%0d req", i), {31'd0, dbus.dbus_req}, 32'd1);
                check($sformatf("v%0d we", i), {31'd0, dbus.dbus_we}, {31'd0, v.we});
                check($sformatf("v%0d addr", i), dbus.dbus_addr, {v.addr[31:2], 2'b00});
                check($sformatf("v%0d be", i), {28'd0, dbus.dbus_be}, {28'd0, v.be});
                check($sformatf("v%0d wdata", i), dbus.dbus_wdata, v.wdata);
                for (int w = 0; w < v.waits; w++) begin
                    check($sformatf("v%0d wait stall", i), {31'd0, stall}, 32'd1);
                    if (stall) stall_cnt++;
                    @(posedge clk);
                    @(negedge clk);
                    #1;
                    check($sformatf("v%0d held addr", i), dbus.dbus_addr, {v.addr[31:2], 2'b00});
                    check($sformatf("v%0d held be", i), {28'd0, dbus.dbus_be}, {28'd0, v.be});
                end
                dbus.dbus_ack   = 1'b1;
                dbus.dbus_rdata = v.rdata;
                #1;
                check($sformatf("v%0d ack stall", i), {31'd0, stall}, 32'd0);
                @(posedge clk);
                @(negedge clk);
                dbus.dbus_ack   = 1'b0;
                dbus.dbus_rdata = 32'h0;
            end
            #1;
            check($sformatf("v%0d stall cycles", i), stall_cnt, v.bus ? v.waits + 1 : 0);
            check($sformatf("v%0d o_valid", i), {31'd0, o_valid}, 32'd1);
            check($sformatf("v%0d o_result", i), o_result, v.result);
            check($sformatf("v%0d o_rd", i), {27'd0, o_rd}, {27'd0, v.rd});
            check($sformatf("v%0d o_cu", i), {24'd0, o_cu}, {24'd0, v.cu});
            check($sformatf("v%0d o_misalign", i), {31'd0, o_misalign}, {31'd0, v.mis});
            check($sformatf("v%0d done req", i), {31'd0, dbus.dbus_req}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            #1;
            check($sformatf("v%0d bubble o_valid", i), {31'd0, o_valid}, 32'd0);
        end

        // Reset while waiting in BUS: request drops, a later ack is ignored.
        @(negedge clk);
        in_valid = 1'b1;
        rd       = 5'd12;
        alu_out  = 32'h0000_5000;
        cu       = 8'h08;
        funct3   = 3'b010;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("midbus req before rst", {31'd0, dbus.dbus_req}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("midbus req", {31'd0, dbus.dbus_req}, 32'd0);
        check("midbus stall", {31'd0, stall}, 32'd0);
        check("midbus o_valid", {31'd0, o_valid}, 32'd0);
        rst             = 1'b0;
        dbus.dbus_ack   = 1'b1;
        dbus.dbus_rdata = 32'h0000_DEAD;
        #1;
        check("late ack stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("late ack o_valid", {31'd0, o_valid}, 32'd0);
        check("late ack req", {31'd0, dbus.dbus_req}, 32'd0);
        check("late ack o_result", o_result, 32'd0);
        dbus.dbus_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
